// File: rtl/pc_fetch.sv
// Instruction fetch stage: one-outstanding-request imem handshake, skid buffer and IF/ID register.
// Optional PC_MISALIGN_TRAP_EN adds a TRAP state for misaligned redirect targets.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pcplus4,
  output logic [31:0] if_id_instr,
  output logic        fetch_trap
);

`ifdef PC_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2,
    S_TRAP    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_req_pc, w_req_pc_nxt;
  logic        r_imem_req, w_imem_req_nxt;
  logic        r_skid_valid, w_skid_valid_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic [31:0] r_skid_pc, w_skid_pc_nxt;
  logic        r_ifid_valid, w_ifid_valid_nxt;
  logic [31:0] r_ifid_pc, w_ifid_pc_nxt;
  logic [31:0] r_ifid_pcplus4, w_ifid_pcplus4_nxt;
  logic [31:0] r_ifid_instr, w_ifid_instr_nxt;
  logic [31:0] w_redir_pc;
  logic        w_accept;

`ifdef PC_MISALIGN_TRAP_EN
  logic        r_trap, w_trap_nxt;
  logic        w_misalign;
  assign w_misalign = |redirect_pc[1:0];
  assign w_redir_pc = redirect_pc;
  assign fetch_trap = r_trap;
`else
  // Without the trap, targets are silently word-aligned.
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_trap = 1'b0;
`endif

  assign w_accept      = r_imem_req & imem_gnt;
  assign imem_req      = r_imem_req;
  assign imem_addr     = r_pc;
  assign if_id_valid   = r_ifid_valid;
  assign if_id_pc      = r_ifid_pc;
  assign if_id_pcplus4 = r_ifid_pcplus4;
  assign if_id_instr   = r_ifid_instr;

  // Next-state, PC, skid and IF/ID update; redirect overrides everything else.
  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_req_pc_nxt       = r_req_pc;
    w_skid_valid_nxt   = r_skid_valid;
    w_skid_instr_nxt   = r_skid_instr;
    w_skid_pc_nxt      = r_skid_pc;
    w_ifid_valid_nxt   = r_ifid_valid;
    w_ifid_pc_nxt      = r_ifid_pc;
    w_ifid_pcplus4_nxt = r_ifid_pcplus4;
    w_ifid_instr_nxt   = r_ifid_instr;
`ifdef PC_MISALIGN_TRAP_EN
    w_trap_nxt         = r_trap;
`endif
    if (redirect_valid) begin
      w_pc_nxt         = w_redir_pc;
      w_ifid_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      if (w_misalign) begin
        w_state_nxt = S_TRAP;
        w_trap_nxt  = 1'b1;
      end else begin
        w_trap_nxt  = 1'b0;
`endif
        // Any request already accepted still owes a response that must be dropped.
        case (r_state)
          S_REQ:     w_state_nxt = w_accept    ? S_DISCARD : S_REQ;
          S_WAIT:    w_state_nxt = imem_rvalid ? S_REQ     : S_DISCARD;
          S_DISCARD: w_state_nxt = imem_rvalid ? S_REQ     : S_DISCARD;
          default:   w_state_nxt = S_REQ;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
      end
`endif
    end else begin
      if (!stall) begin
        w_ifid_valid_nxt = 1'b0;
      end else begin
        w_ifid_valid_nxt = r_ifid_valid;
      end
      case (r_state)
        S_REQ: begin
          if (r_skid_valid && !stall) begin
            w_skid_valid_nxt   = 1'b0;
            w_ifid_valid_nxt   = 1'b1;
            w_ifid_pc_nxt      = r_skid_pc;
            w_ifid_pcplus4_nxt = r_skid_pc + 32'd4;
            w_ifid_instr_nxt   = r_skid_instr;
          end else begin
            w_skid_valid_nxt   = r_skid_valid;
          end
          if (w_accept) begin
            w_req_pc_nxt = r_pc;
            w_pc_nxt     = r_pc + 32'd4;
            w_state_nxt  = S_WAIT;
          end else begin
            w_state_nxt  = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (!r_ifid_valid || !stall) begin
              w_ifid_valid_nxt   = 1'b1;
              w_ifid_pc_nxt      = r_req_pc;
              w_ifid_pcplus4_nxt = r_req_pc + 32'd4;
              w_ifid_instr_nxt   = imem_rdata;
            end else begin
              w_skid_valid_nxt   = 1'b1;
              w_skid_pc_nxt      = r_req_pc;
              w_skid_instr_nxt   = imem_rdata;
            end
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
        S_DISCARD: w_state_nxt = imem_rvalid ? S_REQ : S_DISCARD;
`ifdef PC_MISALIGN_TRAP_EN
        S_TRAP: begin
          w_ifid_valid_nxt = 1'b0;
          w_state_nxt      = S_TRAP;
        end
`endif
        default: w_state_nxt = S_REQ;
      endcase
    end
    w_imem_req_nxt = (w_state_nxt == S_REQ) && !w_skid_valid_nxt;
  end

  // State and datapath registers; imem_req is registered so it stays low through reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_REQ;
      r_pc           <= RESET_PC;
      r_req_pc       <= 32'h0000_0000;
      r_imem_req     <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_skid_instr   <= 32'h0000_0000;
      r_skid_pc      <= 32'h0000_0000;
      r_ifid_valid   <= 1'b0;
      r_ifid_pc      <= 32'h0000_0000;
      r_ifid_pcplus4 <= 32'h0000_0000;
      r_ifid_instr   <= 32'h0000_0000;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_req_pc       <= w_req_pc_nxt;
      r_imem_req     <= w_imem_req_nxt;
      r_skid_valid   <= w_skid_valid_nxt;
      r_skid_instr   <= w_skid_instr_nxt;
      r_skid_pc      <= w_skid_pc_nxt;
      r_ifid_valid   <= w_ifid_valid_nxt;
      r_ifid_pc      <= w_ifid_pc_nxt;
      r_ifid_pcplus4 <= w_ifid_pcplus4_nxt;
      r_ifid_instr   <= w_ifid_instr_nxt;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Misaligned-target trap flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_trap <= 1'b0;
    end else begin
      r_trap <= w_trap_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch; a second instance with RESET_PC=32'hFFFF_FFFC checks PC wrap.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req, w_req;
  logic [31:0] imem_addr, w_addr;
  logic        if_id_valid, w_valid;
  logic [31:0] if_id_pc, if_id_pcplus4, if_id_instr, w_pc, w_pcplus4, w_instr;
  logic        fetch_trap, w_trap;
  int n_cmp = 0;
  int n_err = 0;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_pcplus4(if_id_pcplus4), .if_id_instr(if_id_instr),
    .fetch_trap(fetch_trap));

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rstn(rstn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_id_valid(w_valid),
    .if_id_pc(w_pc), .if_id_pcplus4(w_pcplus4), .if_id_instr(w_instr),
    .fetch_trap(w_trap));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", if_id_valid); end
    n_cmp++; if ({if_id_pc, if_id_pcplus4, if_id_instr} !== 96'h0) begin n_err++; $display("FAIL rst_ifid: got %h %h %h want 0", if_id_pc, if_id_pcplus4, if_id_instr); end
    n_cmp++; if (fetch_trap !== 1'b0) begin n_err++; $display("FAIL rst_trap: got %b want 0", fetch_trap); end
    n_cmp++; if (w_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL rst_wrap_addr: got %h want fffffffc", w_addr); end
    rstn = 1'b1;
    step();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rst_req_after: got %b want 1", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] k4;
    for (int k = 0; k < 3; k++) begin
      k4 = 32'(k) * 32'd4;
      imem_gnt = 1'b1;
      step();
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL seq_wait_req[%0d]: got %b want 0", k, imem_req); end
      if (k == 0) begin
        n_cmp++; if (w_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", w_addr); end
      end
      imem_rvalid = 1'b1;
      imem_rdata = 32'h0000_1000 + 32'(k);
      step();
      imem_rvalid = 1'b0;
      n_cmp++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", k, if_id_valid); end
      n_cmp++; if (if_id_pc !== k4) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", k, if_id_pc, k4); end
      n_cmp++; if (if_id_pcplus4 !== k4 + 32'd4) begin n_err++; $display("FAIL seq_pcplus4[%0d]: got %h want %h", k, if_id_pcplus4, k4 + 32'd4); end
      n_cmp++; if (if_id_instr !== 32'h0000_1000 + 32'(k)) begin n_err++; $display("FAIL seq_instr[%0d]: got %h", k, if_id_instr); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== k4 + 32'd4) begin n_err++; $display("FAIL seq_next_req[%0d]: got %b/%h want 1/%h", k, imem_req, imem_addr, k4 + 32'd4); end
      if (k == 0) begin
        n_cmp++; if (w_pc !== 32'hFFFF_FFFC || w_pcplus4 !== 32'h0) begin n_err++; $display("FAIL wrap_ifid: got %h/%h want fffffffc/0", w_pc, w_pcplus4); end
      end
    end
  endtask

  task automatic test_stall_skid();
    stall = 1'b1;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    imem_gnt = 1'b1;
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instr !== 32'h0000_1002) begin n_err++; $display("FAIL stall_hold: got %b %h %h want 1 8 1002", if_id_valid, if_id_pc, if_id_instr); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL skid_no_req: got %b want 0", imem_req); end
    step();
    n_cmp++; if (imem_req !== 1'b0 || if_id_instr !== 32'h0000_1002) begin n_err++; $display("FAIL skid_hold2: got %b %h want 0 1002", imem_req, if_id_instr); end
    stall = 1'b0;
    step();
    imem_gnt = 1'b0;
    n_cmp++; if (if_id_instr !== 32'h0050_0093 || if_id_pc !== 32'hC || if_id_pcplus4 !== 32'h10 || if_id_valid !== 1'b1) begin n_err++; $display("FAIL skid_release: got %b %h %h %h", if_id_valid, if_id_pc, if_id_pcplus4, if_id_instr); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL skid_req_resume: got %b %h want 1 10", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin n_err++; $display("FAIL rw_discard: got req %b valid %b want 0 0", imem_req, if_id_valid); end
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rw_dropped: got %b want 0", if_id_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL rw_addr: got %b %h want 1 100", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rw_still_empty: got %b want 0", if_id_valid); end
    imem_rvalid = 1'b1;
    imem_rdata = 32'h00A0_0113;
    step();
    imem_rvalid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== 32'h00A0_0113) begin n_err++; $display("FAIL rw_target: got %b %h %h", if_id_valid, if_id_pc, if_id_instr); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    stall = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rs_flush: got %b want 0", if_id_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL rs_pc: got %b %h want 1 40", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_edges();
    imem_gnt = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0080;
    step();
    imem_gnt = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h80) begin n_err++; $display("FAIL rg_discard: got %b %h want 0 80", imem_req, imem_addr); end
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_1111;
    step();
    imem_rvalid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1) begin n_err++; $display("FAIL rg_dropped: got valid %b req %b want 0 1", if_id_valid, imem_req); end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_00C0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h2222_2222;
    step();
    redirect_valid = 1'b0;
    imem_rvalid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rv_dropped: got %b want 0", if_id_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hC0) begin n_err++; $display("FAIL rv_req: got %b %h want 1 c0", imem_req, imem_addr); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    n_cmp++; if (fetch_trap !== 1'b1 || imem_req !== 1'b0 || if_id_valid !== 1'b0) begin n_err++; $display("FAIL trap_enter: got trap %b req %b valid %b", fetch_trap, imem_req, if_id_valid); end
    step();
    n_cmp++; if (fetch_trap !== 1'b1 || imem_req !== 1'b0) begin n_err++; $display("FAIL trap_hold: got %b %b want 1 0", fetch_trap, imem_req); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (fetch_trap !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL trap_exit: got %b %b %h want 0 1 200", fetch_trap, imem_req, imem_addr); end
`else
    n_cmp++; if (fetch_trap !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL misalign_force: got %b %b %h want 0 1 100", fetch_trap, imem_req, imem_addr); end
`endif
  endtask

  task automatic test_midop_reset();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rstn = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL mr_async: got %b %b %h want 0 0 0", imem_req, if_id_valid, imem_addr); end
    n_cmp++; if (if_id_pc !== 32'h0 || fetch_trap !== 1'b0) begin n_err++; $display("FAIL mr_ifid: got %h %b want 0 0", if_id_pc, fetch_trap); end
    step();
    rstn = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h3333_3333;
    step();
    imem_rvalid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin n_err++; $display("FAIL mr_late_rvalid: got %b %h want 0 0", if_id_valid, if_id_instr); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL mr_restart: got %b %h want 1 0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_stall();
    test_redirect_edges();
    test_misalign();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
